// File: rtl/lfsr_seed_sequencer.sv
// Seeds the 147-bit scrambler LFSR through five 32-bit register writes, then
// steps it once per accepted keystream word over a valid/ready handshake.
module lfsr_seed_sequencer #(
   parameter int          POLY_WIDTH = 147,
   parameter logic [11:0] BASE_ADDR  = 12'h0f0,
   parameter int          CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  seed_valid,
   output logic                  seed_ready,
   input  logic [POLY_WIDTH-1:0] seed,
   input  logic [CNT_WIDTH-1:0]  seed_len,
   input  logic                  abort,
   output logic                  ks_valid,
   input  logic                  ks_ready,
   output logic [POLY_WIDTH-1:0] ks_data,
   output logic                  busy,
   output logic                  done,
   output logic                  lfsr_write,
   output logic [11:0]           lfsr_addr,
   output logic [31:0]           lfsr_din,
   output logic                  lfsr_enable,
   input  logic [POLY_WIDTH-1:0] lfsr_dout
);
   localparam int         NUM_WORDS = (POLY_WIDTH + 31) / 32;
   localparam logic [2:0] LAST_WC   = 3'(NUM_WORDS - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t                  state_q;
   logic [2:0]              wc_q;
   logic [CNT_WIDTH-1:0]    remaining_q;
   logic [POLY_WIDTH-1:0]   seed_q;
   logic [32*NUM_WORDS-1:0] seed_pad;
   logic                    load_act;
   logic                    run_act;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         wc_q        <= '0;
         remaining_q <= '0;
         seed_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (seed_valid) begin
                  seed_q      <= seed;
                  remaining_q <= seed_len;
                  wc_q        <= '0;
                  state_q     <= LOAD;
               end
            end
            LOAD: begin
               if (abort) begin
                  wc_q    <= '0;
                  state_q <= IDLE;
               end else if (wc_q == LAST_WC) begin
                  wc_q    <= '0;
                  state_q <= (remaining_q != '0) ? RUN : DONE;
               end else begin
                  wc_q <= wc_q + 3'd1;
               end
            end
            RUN: begin
               if (abort) begin
                  state_q <= IDLE;
               end else if (ks_ready) begin
                  // Exit on the 1->0 handshake so remaining never wraps.
                  remaining_q <= remaining_q - CNT_WIDTH'(1);
                  if (remaining_q == CNT_WIDTH'(1))
                     state_q <= DONE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      seed_pad                   = '0;
      seed_pad[POLY_WIDTH-1:0]   = seed_q;
   end

   // Abort and reset mask every strobe in the cycle they are seen.
   assign load_act = rst_n && (state_q == LOAD) && !abort;
   assign run_act  = rst_n && (state_q == RUN) && !abort;

   assign seed_ready  = rst_n && (state_q == IDLE);
   assign busy        = rst_n && (state_q != IDLE);
   assign done        = rst_n && (state_q == DONE) && !abort;
   assign ks_valid    = run_act;
   assign ks_data     = run_act ? lfsr_dout : '0;
   assign lfsr_enable = run_act && ks_ready;
   assign lfsr_write  = load_act;
   assign lfsr_addr   = load_act ? (BASE_ADDR + {9'b0, wc_q}) : 12'h000;
   assign lfsr_din    = load_act ? seed_pad[{wc_q, 5'b0} +: 32] : 32'h0;

endmodule

// File: tb/tb_lfsr_seed_sequencer.sv
// Directed bench for lfsr_seed_sequencer with a behavioural 147-bit LFSR
// attached to its register-write/enable port.
module tb_lfsr_seed_sequencer;
   localparam int PW = 147;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          seed_valid;
   logic          seed_ready;
   logic [PW-1:0] seed;
   logic [CW-1:0] seed_len;
   logic          abort;
   logic          ks_valid;
   logic          ks_ready;
   logic [PW-1:0] ks_data;
   logic          busy;
   logic          done;
   logic          lfsr_write;
   logic [11:0]   lfsr_addr;
   logic [31:0]   lfsr_din;
   logic          lfsr_enable;
   logic [PW-1:0] lfsr_dout;
   logic [PW-1:0] lfsr_state;

   int checks = 0;
   int failures = 0;
   int write_cnt = 0;
   int en_cnt = 0;
   int done_cnt = 0;

   always #5 clk = ~clk;

   lfsr_seed_sequencer dut (
      .clk(clk), .rst_n(rst_n), .seed_valid(seed_valid), .seed_ready(seed_ready),
      .seed(seed), .seed_len(seed_len), .abort(abort), .ks_valid(ks_valid),
      .ks_ready(ks_ready), .ks_data(ks_data), .busy(busy), .done(done),
      .lfsr_write(lfsr_write), .lfsr_addr(lfsr_addr), .lfsr_din(lfsr_din),
      .lfsr_enable(lfsr_enable), .lfsr_dout(lfsr_dout)
   );

   function automatic logic [PW-1:0] step1(input logic [PW-1:0] s);
      logic          fb;
      logic [PW-1:0] n;
      fb = s[146];
      n = {s[145:0], fb};
      n[42]  = n[42] ^ fb;
      n[88]  = n[88] ^ fb;
      n[109] = n[109] ^ fb;
      return n;
   endfunction

   function automatic logic [PW-1:0] adv12(input logic [PW-1:0] s);
      logic [PW-1:0] t;
      t = s;
      for (int i = 0; i < 12; i++) t = step1(t);
      return t;
   endfunction

   function automatic logic [31:0] seed_word(input logic [PW-1:0] s, input int i);
      if (i < 4) return s[32*i +: 32];
      return {13'b0, s[146:128]};
   endfunction

   // Behavioural LFSR: register writes and 12-step advance.
   assign lfsr_dout = lfsr_state;
   always @(posedge clk) begin
      if (lfsr_write) begin
         case (lfsr_addr)
            12'h0f0: lfsr_state[31:0]    <= lfsr_din;
            12'h0f1: lfsr_state[63:32]   <= lfsr_din;
            12'h0f2: lfsr_state[95:64]   <= lfsr_din;
            12'h0f3: lfsr_state[127:96]  <= lfsr_din;
            12'h0f4: lfsr_state[146:128] <= lfsr_din[18:0];
            default: ;
         endcase
      end else if (lfsr_enable) begin
         lfsr_state <= adv12(lfsr_state);
      end
   end

   always @(negedge clk) begin
      if (lfsr_write) write_cnt++;
      if (lfsr_enable) en_cnt++;
      if (done) done_cnt++;
      checks++;
      assert (!(lfsr_write && lfsr_enable)) else begin
         failures++;
         $error("FAIL excl observed write=%0b enable=%0b expected not both", lfsr_write, lfsr_enable);
      end
      checks++;
      assert (lfsr_write || (lfsr_addr === 12'h0 && lfsr_din === 32'h0)) else begin
         failures++;
         $error("FAIL idle_bus observed addr=%h din=%h expected 0/0", lfsr_addr, lfsr_din);
      end
   end

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic request(input logic [PW-1:0] s, input logic [CW-1:0] n);
      seed_valid = 1'b1;
      seed = s;
      seed_len = n;
      #1 check("accept_ready", seed_ready, 1'b1);
      next();
      seed_valid = 1'b0;
   endtask

   task automatic load_phase(input logic [PW-1:0] s);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("ld_write", lfsr_write, 1'b1);
         check("ld_addr", lfsr_addr, 12'h0f0 + 12'(i));
         check("ld_din", lfsr_din, seed_word(s, i));
         check("ld_busy", busy, 1'b1);
         check("ld_noks", ks_valid, 1'b0);
         next();
      end
   endtask

   logic [PW-1:0] s1, s2, s3, exp_w, w1, w2;
   logic [11:0]   addr_tab[5];
   logic [31:0]   din_tab[5];
   logic          rdy_pat[6];
   int            e0, d0, wr0;

   initial begin
      rst_n = 1'b0; seed_valid = 1'b0; seed = '0; seed_len = '0;
      abort = 1'b0; ks_ready = 1'b0;
      #3;
      check("rst_ready", seed_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_write", lfsr_write, 1'b0);
      next();
      next();
      check("rst_ready_hold", seed_ready, 1'b0);
      rst_n = 1'b1;
      #1;
      check("post_rst_ready", seed_ready, 1'b1);
      check("post_rst_busy", busy, 1'b0);
      check("post_rst_done", done, 1'b0);
      check("post_rst_ksv", ks_valid, 1'b0);

      // Load and single word, against a hand-written write table.
      s1 = {19'h5A5A5, 32'h0BADF00D, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF};
      addr_tab = '{12'h0f0, 12'h0f1, 12'h0f2, 12'h0f3, 12'h0f4};
      din_tab  = '{32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h0BADF00D, 32'h0005A5A5};
      ks_ready = 1'b1;
      e0 = en_cnt;
      request(s1, 16'd1);
      for (int i = 0; i < 5; i++) begin
         #1;
         check("t1_write", lfsr_write, 1'b1);
         check("t1_addr", lfsr_addr, addr_tab[i]);
         check("t1_din", lfsr_din, din_tab[i]);
         next();
      end
      #1;
      check("t1_ksv", ks_valid, 1'b1);
      check("t1_data", ks_data, s1);
      check("t1_en", lfsr_enable, 1'b1);
      next();
      #1;
      check("t1_done", done, 1'b1);
      check("t1_ksv_off", ks_valid, 1'b0);
      next();
      #1;
      check("t1_ready_back", seed_ready, 1'b1);
      check("t1_done_off", done, 1'b0);
      check("t1_en_count", en_cnt - e0, 1);
      $display("txn load_single enables=%0d", en_cnt - e0);

      // Streaming, accepted in the first IDLE cycle (back-to-back).
      s2 = {19'h7FFFF, 32'h89ABCDEF, 32'h01234567, 32'hF0E1D2C3, 32'hA5A5A5A5};
      e0 = en_cnt;
      request(s2, 16'd4);
      load_phase(s2);
      exp_w = s2;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("t2_ksv", ks_valid, 1'b1);
         check("t2_data", ks_data, exp_w);
         exp_w = adv12(exp_w);
         next();
      end
      #1;
      check("t2_done", done, 1'b1);
      check("t2_en_count", en_cnt - e0, 4);
      next();
      $display("txn stream words=4 enables=%0d", en_cnt - e0);

      // Backpressure with a single-bit seed; words 1 and 2 worked out by hand.
      s3 = '0; s3[146] = 1'b1;
      w1 = '0; w1[11] = 1'b1; w1[53] = 1'b1; w1[99] = 1'b1; w1[120] = 1'b1;
      w2 = '0; w2[23] = 1'b1; w2[65] = 1'b1; w2[111] = 1'b1; w2[132] = 1'b1;
      rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      e0 = en_cnt;
      request(s3, 16'd3);
      load_phase(s3);
      for (int i = 0; i < 6; i++) begin
         ks_ready = rdy_pat[i];
         #1;
         check("t3_data", ks_data, (i == 0) ? s3 : ((i < 4) ? w1 : w2));
         check("t3_en", lfsr_enable, rdy_pat[i]);
         check("t3_nodone", done, 1'b0);
         next();
      end
      ks_ready = 1'b1;
      #1;
      check("t3_done", done, 1'b1);
      check("t3_en_count", en_cnt - e0, 3);
      next();
      $display("txn backpressure words=3 enables=%0d", en_cnt - e0);

      // Zero length.
      e0 = en_cnt; wr0 = write_cnt;
      request(s1, 16'd0);
      load_phase(s1);
      #1;
      check("t4_done", done, 1'b1);
      check("t4_ksv", ks_valid, 1'b0);
      check("t4_writes", write_cnt - wr0, 5);
      check("t4_en_count", en_cnt - e0, 0);
      next();
      #1 check("t4_ready", seed_ready, 1'b1);
      $display("txn zero_len writes=%0d", write_cnt - wr0);

      // Abort during LOAD at wc=2.
      wr0 = write_cnt; d0 = done_cnt;
      request(s2, 16'd3);
      next();
      next();
      abort = 1'b1;
      #1;
      check("t5_write_masked", lfsr_write, 1'b0);
      check("t5_addr_zero", lfsr_addr, 12'h0);
      next();
      abort = 1'b0;
      #1;
      check("t5_ready", seed_ready, 1'b1);
      check("t5_busy", busy, 1'b0);
      next(); next(); next();
      check("t5_writes", write_cnt - wr0, 2);
      check("t5_nodone", done_cnt - d0, 0);
      $display("txn abort_load writes=%0d", write_cnt - wr0);

      // Abort in RUN after one of five words.
      e0 = en_cnt; d0 = done_cnt;
      request(s2, 16'd5);
      load_phase(s2);
      #1 check("t6_word0", ks_data, s2);
      next();
      abort = 1'b1;
      #1;
      check("t6_ksv_masked", ks_valid, 1'b0);
      check("t6_en_masked", lfsr_enable, 1'b0);
      next();
      abort = 1'b0;
      #1;
      check("t6_ready", seed_ready, 1'b1);
      check("t6_busy", busy, 1'b0);
      check("t6_ksv", ks_valid, 1'b0);
      next(); next();
      check("t6_en_count", en_cnt - e0, 1);
      check("t6_nodone", done_cnt - d0, 0);
      $display("txn abort_run enables=%0d", en_cnt - e0);

      // Reset mid-run, then a normal request.
      request(s1, 16'd5);
      load_phase(s1);
      next();
      rst_n = 1'b0;
      #1;
      check("t7_rst_ready", seed_ready, 1'b0);
      check("t7_rst_ksv", ks_valid, 1'b0);
      check("t7_rst_en", lfsr_enable, 1'b0);
      check("t7_rst_busy", busy, 1'b0);
      next();
      rst_n = 1'b1;
      #1;
      check("t7_ready", seed_ready, 1'b1);
      check("t7_busy", busy, 1'b0);
      check("t7_ksv", ks_valid, 1'b0);
      check("t7_write", lfsr_write, 1'b0);
      check("t7_done", done, 1'b0);
      e0 = en_cnt;
      request(s3, 16'd2);
      load_phase(s3);
      #1 check("t7_w0", ks_data, s3);
      next();
      #1 check("t7_w1", ks_data, w1);
      next();
      #1 check("t7_done_pulse", done, 1'b1);
      next();
      #1 check("t7_ready_back", seed_ready, 1'b1);
      check("t7_en_count", en_cnt - e0, 2);
      $display("txn reset_recover enables=%0d", en_cnt - e0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/lfsr_seed_sequencer.md
# lfsr_seed_sequencer

Controller for the 147-bit scrambler LFSR. It accepts a seed and a keystream length from an upstream requester and writes the seed into the LFSR as five 32-bit register writes. It then advances the LFSR once per accepted keystream word and presents the LFSR state to a downstream consumer over a valid/ready handshake. It sits between the block's control logic and the LFSR's register-write/enable port, and is the only driver of that port.

## Interface
- POLY_WIDTH, 147, LFSR state width.
- BASE_ADDR, 12'h0f0, address of seed word 0; words 1..4 are at BASE_ADDR+1..+4.
- CNT_WIDTH, 16, width of the keystream length field.
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- seed_valid  in  1  seed request valid.
- seed_ready  out  1  sequencer can accept a request.
- seed  in  POLY_WIDTH  initial LFSR state.
- seed_len  in  CNT_WIDTH  number of keystream words to emit.
- abort  in  1  cancel the current operation.
- ks_valid  out  1  keystream word valid.
- ks_ready  in  1  consumer accepts the word.
- ks_data  out  POLY_WIDTH  keystream word, equal to lfsr_dout.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a request completes.
- lfsr_write  out  1  LFSR register write strobe.
- lfsr_addr  out  12  LFSR register address.
- lfsr_din  out  32  LFSR write data.
- lfsr_enable  out  1  LFSR advance: 12 steps per cycle asserted.
- lfsr_dout  in  POLY_WIDTH  current LFSR state.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - seed_ready=1.
  - On seed_valid&seed_ready: capture seed into seed_q and seed_len into remaining; clear word counter wc; go to LOAD.
- **LOAD** (5 cycles, wc=0..4)
  - lfsr_write=1 and lfsr_addr=BASE_ADDR+wc.
  - lfsr_din=seed_q[32wc+31:32wc] for wc=0..3.
  - For wc=4, lfsr_din={13'b0, seed_q[146:128]}.
  - After wc=4: go to RUN if remaining!=0, else go to DONE.
- **RUN**
  - ks_valid=1 and ks_data=lfsr_dout.
  - lfsr_enable=ks_valid&ks_ready (combinational).
  - Each handshake decrements remaining.
  - The handshake that takes remaining from 1 to 0 moves the state to DONE.
- **DONE**: done=1 for one cycle, then IDLE.
- Word ordering: the first emitted word is the loaded seed. Word k is the seed advanced 12·k steps.
- Exclusivity: lfsr_write and lfsr_enable are never high in the same cycle. In every non-asserting cycle, lfsr_addr=0 and lfsr_din=0.
- **abort**
  - Sampled in LOAD, RUN and DONE. Next state is IDLE.
  - In the abort cycle itself: lfsr_write, lfsr_enable and ks_valid are forced to 0, and done is not pulsed.
  - A partially loaded LFSR is left as is.
  - abort is ignored in IDLE.
- Width rules: remaining is CNT_WIDTH bits, loaded directly from seed_len and decremented only on a handshake. It never wraps, because RUN exits at 1→0.
- The consumer may hold ks_ready low indefinitely. While it does, ks_data stays stable and the LFSR does not advance.

## Timing
- Reset (rst_n=0 at an edge): state=IDLE, wc=0, remaining=0, seed_q=0.
- Outputs during reset and in the first cycle after release: seed_ready=0 while rst_n=0, then 1; all other outputs 0.
- Request accepted at edge T (cycle T has seed_valid&seed_ready):
  - LOAD occupies cycles T+1..T+5.
  - RUN starts at T+6 with ks_valid=1 and ks_data=seed.
- With ks_ready held at 1, N words occupy cycles T+6..T+5+N, done is at T+6+N, and seed_ready returns at T+7+N.
- seed_len=0: done at T+6, IDLE at T+7.
- Back-to-back: a new request is accepted in the first IDLE cycle. No bubble is required beyond DONE.
- seed_ready is registered-state-derived and does not depend combinationally on seed_valid.
- ks_valid and busy depend only on state. lfsr_enable depends combinationally on ks_ready.

## Test plan
- **Load and single word.**
  - Stimulus: seed={19'h5A5A5, 32'h0BADF00D, 32'h12345678, 32'hCAFEBABE, 32'hDEADBEEF}, seed_len=1, ks_ready=1.
  - Required writes, in order: (0f0, DEADBEEF), (0f1, CAFEBABE), (0f2, 12345678), (0f3, 0BADF00D), (0f4, 0005A5A5).
  - Then one word equal to the seed, exactly one lfsr_enable, and done at T+7.
- **Streaming.**
  - Stimulus: seed_len=4, ks_ready=1.
  - Required: 4 consecutive words matching a golden 12-step-per-word model of the LFSR (taps feeding bits 42, 88, 109 and bit 0 from bit 146), and done at T+10.
- **Backpressure.**
  - Stimulus: seed_len=3, ks_ready pattern 1,0,0,1,0,1.
  - Required: ks_data stable while ks_ready=0, lfsr_enable high only on the 3 handshake cycles, and done the cycle after the third handshake.
- **Zero length.**
  - Stimulus: seed_len=0.
  - Required: 5 writes, no ks_valid, no lfsr_enable, done at T+6.
- **Abort.**
  - Stimulus: abort during LOAD at wc=2, then separately abort in RUN after 1 of 5 words.
  - Required: the next cycle is IDLE with seed_ready=1, no further write/enable, and no done.
- **Reset mid-run.**
  - Stimulus: rst_n=0 for one edge during RUN.
  - Required: all outputs 0 the following cycle, and a new request is then accepted and completes normally.
